// File: rtl/gmac_tx_chan_arb_if.sv
// Handshake bundle between the TX byte sources and the channel arbiter.
// Sources drive through 'master'; the arbiter attaches through 'slave'.
interface gmac_tx_chan_arb_if #(
  parameter int NCH = 2,
  parameter int DW  = 8
);
  localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0]    ValIn;
  logic [NCH-1:0]    SoFIn;
  logic [NCH-1:0]    EoFIn;
  logic [NCH-1:0]    ReqIn;
  logic [NCH*DW-1:0] DataIn;
  logic [NCH-1:0]    ReqConfirm;
  logic              ValOut;
  logic              SoFOut;
  logic              EoFOut;
  logic [DW-1:0]     DataOut;
  logic              ErrOut;
  logic [GW-1:0]     GrantIdx;
  logic              Busy;

  modport master (
    output ValIn, SoFIn, EoFIn, ReqIn, DataIn,
    input  ReqConfirm, ValOut, SoFOut, EoFOut, DataOut, ErrOut, GrantIdx, Busy
  );

  modport slave (
    input  ValIn, SoFIn, EoFIn, ReqIn, DataIn,
    output ReqConfirm, ValOut, SoFOut, EoFOut, DataOut, ErrOut, GrantIdx, Busy
  );
endinterface

// File: rtl/gmac_tx_chan_arb.sv
// Round-robin TX channel arbiter/mux with idle-timeout abort and inter-frame gap.
// Optional GMAC_ARB_PRIO0_EN: channel 0 gets strict priority over the round-robin group.
//
// state    | meaning
// IDLE     | no grant; requests sampled, winner chosen
// WAIT_SOF | grant issued, waiting for the first (SoF) beat
// XFER     | frame in progress, forwarding beats until EoF
// GAP      | inter-frame gap after EoF / release / abort
module gmac_tx_chan_arb #(
  parameter int NCH     = 2,
  parameter int DW      = 8,
  parameter int IFG     = 12,
  parameter int TIMEOUT = 1023
) (
  input logic               clk125,
  input logic               rst_n,
  gmac_tx_chan_arb_if.slave bus
);
  localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam int CW = (IFG > 1) ? $clog2(IFG) : 1;
  localparam logic [TW-1:0] TLOAD = TW'(TIMEOUT - 1);
  localparam logic [CW-1:0] GLOAD = CW'((IFG > 0) ? IFG - 1 : 0);
`ifdef GMAC_ARB_PRIO0_EN
  localparam int RR_LO = 1;
`else
  localparam int RR_LO = 0;
`endif

  typedef enum logic [1:0] {IDLE, WAIT_SOF, XFER, GAP} state_t;

  state_t         state, state_nxt;
  logic [GW-1:0]  ptr, ptr_nxt, gidx, gidx_nxt, win;
  logic [NCH-1:0] conf, conf_nxt;
  logic           val_q, val_nxt, sof_q, sof_nxt, eof_q, eof_nxt, err_q, err_nxt;
  logic [DW-1:0]  data_q, data_nxt;
  logic [TW-1:0]  tcnt, tcnt_nxt;
  logic [CW-1:0]  gcnt, gcnt_nxt;
  logic           prio0, tc_hit, gap_done, any_req;
  logic           g_val, g_sof, g_eof, g_req;
  logic [DW-1:0]  g_data;
  logic [DW-1:0]  data_ch [NCH];

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign data_ch[i] = bus.DataIn[i*DW +: DW];
  end

  assign g_val    = bus.ValIn[gidx];
  assign g_sof    = bus.SoFIn[gidx];
  assign g_eof    = bus.EoFIn[gidx];
  assign g_req    = bus.ReqIn[gidx];
  assign g_data   = data_ch[gidx];
  assign tc_hit   = (tcnt == '0);
  assign gap_done = (gcnt == '0);
  assign any_req  = |bus.ReqIn;

`ifdef GMAC_ARB_PRIO0_EN
  assign prio0 = bus.ReqIn[0];
`else
  assign prio0 = 1'b0;
`endif

  // Winner search starts just after the last round-robin grant.
  always_comb begin
    int j;
    logic found;
    win   = ptr;
    found = 1'b0;
    for (int i = 1; i <= NCH; i++) begin
      j = int'(ptr) + i;
      if (j >= NCH) j -= NCH;
      if (!found && j >= RR_LO && bus.ReqIn[j[GW-1:0]]) begin
        win   = j[GW-1:0];
        found = 1'b1;
      end
    end
    if (prio0) win = '0;
  end

  always_ff @(posedge clk125 or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ptr    <= GW'(NCH - 1);
      gidx   <= '0;
      conf   <= '0;
      val_q  <= 1'b0;
      sof_q  <= 1'b0;
      eof_q  <= 1'b0;
      err_q  <= 1'b0;
      data_q <= '0;
      tcnt   <= '0;
      gcnt   <= '0;
    end else begin
      state  <= state_nxt;
      ptr    <= ptr_nxt;
      gidx   <= gidx_nxt;
      conf   <= conf_nxt;
      val_q  <= val_nxt;
      sof_q  <= sof_nxt;
      eof_q  <= eof_nxt;
      err_q  <= err_nxt;
      data_q <= data_nxt;
      tcnt   <= tcnt_nxt;
      gcnt   <= gcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (any_req) state_nxt = WAIT_SOF;
      WAIT_SOF: begin
        if (!g_req)              state_nxt = GAP;
        else if (g_val && g_sof) state_nxt = g_eof ? GAP : XFER;
        else if (tc_hit)         state_nxt = GAP;
      end
      XFER: begin
        if (g_val) begin
          if (g_eof) state_nxt = GAP;
        end else if (tc_hit) begin
          state_nxt = GAP;
        end
      end
      GAP:      if (gap_done) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // An accepted beat outranks a same-cycle timeout, so EoF always wins.
  always_comb begin
    conf_nxt = conf;
    gidx_nxt = gidx;
    ptr_nxt  = ptr;
    val_nxt  = 1'b0;
    sof_nxt  = 1'b0;
    eof_nxt  = 1'b0;
    err_nxt  = 1'b0;
    data_nxt = data_q;
    tcnt_nxt = tcnt;
    gcnt_nxt = gcnt;
    case (state)
      IDLE: if (any_req) begin
        conf_nxt      = '0;
        conf_nxt[win] = 1'b1;
        gidx_nxt      = win;
        if (!prio0) ptr_nxt = win;
        tcnt_nxt      = TLOAD;
      end
      WAIT_SOF: begin
        if (!g_req) begin
          conf_nxt = '0;
        end else if (g_val && g_sof) begin
          val_nxt  = 1'b1;
          sof_nxt  = 1'b1;
          eof_nxt  = g_eof;
          data_nxt = g_data;
          tcnt_nxt = TLOAD;
          if (g_eof) conf_nxt = '0;
        end else begin
          err_nxt = g_val;
          if (tc_hit) begin
            err_nxt  = 1'b1;
            conf_nxt = '0;
          end else begin
            tcnt_nxt = tcnt - 1'b1;
          end
        end
      end
      XFER: begin
        if (g_val) begin
          val_nxt  = 1'b1;
          sof_nxt  = g_sof;
          eof_nxt  = g_eof;
          err_nxt  = g_sof;
          data_nxt = g_data;
          tcnt_nxt = TLOAD;
          if (g_eof) conf_nxt = '0;
        end else if (tc_hit) begin
          eof_nxt  = 1'b1;
          err_nxt  = 1'b1;
          data_nxt = '0;
          conf_nxt = '0;
        end else begin
          tcnt_nxt = tcnt - 1'b1;
        end
      end
      GAP:     if (!gap_done) gcnt_nxt = gcnt - 1'b1;
      default: ;
    endcase
    if (state != GAP && state_nxt == GAP) gcnt_nxt = GLOAD;
  end

  assign bus.ReqConfirm = conf;
  assign bus.ValOut     = val_q;
  assign bus.SoFOut     = sof_q;
  assign bus.EoFOut     = eof_q;
  assign bus.DataOut    = data_q;
  assign bus.ErrOut     = err_q;
  assign bus.GrantIdx   = gidx;
  assign bus.Busy       = (state != IDLE);
endmodule
